// File: rtl/icon_channel_arbiter_pkg.sv
// Shared types for the interconnect channel arbiter: per-channel state and allocation record.
package exec_unit_dtypes;

    localparam int ICON_ID_W = 8;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } type_icon_ch_state;

    typedef struct packed {
        type_icon_ch_state      busy;
        logic [ICON_ID_W-1:0]   owner;
        logic [ICON_ID_W-1:0]   dest;
    } type_icon_ch_alloc;

    localparam type_icon_ch_alloc ICON_CH_FREE = '{busy: CH_IDLE, owner: '0, dest: '0};

endpackage

// File: rtl/icon_channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after start that is not excluded.
module icon_rr_picker #(
    parameter int  NUM_UNITS = 2,
    localparam int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [UNIT_W-1:0]    start,
    input  logic [NUM_UNITS-1:0] excl,
    output logic [NUM_UNITS-1:0] win,
    output logic                 valid
);

    logic [NUM_UNITS-1:0] cand;
    int                   idx;

    always_comb begin
        cand  = req & ~excl;
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = (int'(start) + i) % NUM_UNITS;
            if (!valid && cand[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icon_channel_arbiter.sv
// Allocates shared interconnect channels to execution units, round-robin across units,
// with at most one active channel per destination; grants are registered (1-cycle latency).
//
// state   | meaning
// CH_IDLE | channel free, owner/dest read as 0
// CH_BUSY | channel held by owner towards dest until owner pulses release
module icon_channel_arbiter
    import exec_unit_dtypes::*;
#(
    parameter int  NUM_CHANNELS = 2,
    parameter int  NUM_UNITS    = 2,
    localparam int UNIT_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic [NUM_UNITS-1:0]                    i_req,
    input  logic [NUM_UNITS-1:0][UNIT_W-1:0]        i_req_dest,
    input  logic [NUM_UNITS-1:0]                    i_release,
    output logic [NUM_UNITS-1:0]                    o_grant,
    output logic [NUM_UNITS-1:0][CH_W-1:0]          o_grant_ch,
    output logic [NUM_UNITS-1:0]                    o_held,
    output logic [NUM_CHANNELS-1:0]                 o_ch_busy,
    output logic [NUM_CHANNELS-1:0][UNIT_W-1:0]     o_ch_owner,
    output logic [NUM_CHANNELS-1:0][UNIT_W-1:0]     o_ch_dest
);

    type_icon_ch_alloc                  ch_q [NUM_CHANNELS];
    type_icon_ch_alloc                  ch_d [NUM_CHANNELS];
    logic [NUM_UNITS-1:0]               held_q, held_d;
    logic [NUM_UNITS-1:0]               grant_q, grant_d;
    logic [NUM_UNITS-1:0][CH_W-1:0]     grant_ch_q, grant_ch_d;
    logic [UNIT_W-1:0]                  rr_q, rr_d;

    logic [NUM_UNITS-1:0]               dest_busy;
    logic [NUM_UNITS-1:0]               elig;
    logic [NUM_CHANNELS-1:0][NUM_UNITS-1:0] win_all;
    logic [NUM_CHANNELS-1:0]            valid_all;

    // Eligibility is judged on registered state only, so a channel freed this edge stays busy here.
    always_comb begin
        dest_busy = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_q[c].busy == CH_BUSY) dest_busy[ch_q[c].dest[UNIT_W-1:0]] = 1'b1;
        end
        elig = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            elig[u] = i_req[u] && !held_q[u] && !dest_busy[i_req_dest[u]];
        end
    end

    // One picker per channel; each stage excludes earlier winners and anyone sharing their destination.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pick
        logic [NUM_UNITS-1:0] excl_in;
        logic [NUM_UNITS-1:0] excl_out;
        logic [NUM_UNITS-1:0] pick_req;
        logic [NUM_UNITS-1:0] win;
        logic                 valid;
        logic [NUM_UNITS-1:0] same_dest;
        logic [UNIT_W-1:0]    win_dest;

        if (c == 0) begin : g_first
            assign excl_in = '0;
        end else begin : g_next
            assign excl_in = g_pick[c-1].excl_out;
        end

        assign pick_req = (ch_q[c].busy == CH_IDLE) ? elig : '0;

        icon_rr_picker #(.NUM_UNITS(NUM_UNITS)) u_picker (
            .req   (pick_req),
            .start (rr_q),
            .excl  (excl_in),
            .win   (win),
            .valid (valid)
        );

        always_comb begin
            win_dest = '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (win[u]) win_dest = i_req_dest[u];
            end
            same_dest = '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                same_dest[u] = valid && (i_req_dest[u] == win_dest);
            end
        end

        assign excl_out     = excl_in | win | same_dest;
        assign win_all[c]   = win;
        assign valid_all[c] = valid;
    end

    always_comb begin
        ch_d       = ch_q;
        held_d     = held_q;
        grant_d    = '0;
        grant_ch_d = grant_ch_q;
        rr_d       = rr_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_q[c].busy == CH_BUSY && i_release[ch_q[c].owner[UNIT_W-1:0]]) begin
                held_d[ch_q[c].owner[UNIT_W-1:0]]     = 1'b0;
                grant_ch_d[ch_q[c].owner[UNIT_W-1:0]] = '0;
                ch_d[c]                               = ICON_CH_FREE;
            end
        end
        // Later channels hold later walk positions, so the last assignment sets the pointer.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (valid_all[c] && win_all[c][u]) begin
                    ch_d[c].busy  = CH_BUSY;
                    ch_d[c].owner = ICON_ID_W'(u);
                    ch_d[c].dest  = ICON_ID_W'(i_req_dest[u]);
                    held_d[u]     = 1'b1;
                    grant_d[u]    = 1'b1;
                    grant_ch_d[u] = CH_W'(c);
                    rr_d          = (u == NUM_UNITS - 1) ? '0 : UNIT_W'(u + 1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) ch_q[c] <= ICON_CH_FREE;
            held_q     <= '0;
            grant_q    <= '0;
            grant_ch_q <= '0;
            rr_q       <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) ch_q[c] <= ch_d[c];
            held_q     <= held_d;
            grant_q    <= grant_d;
            grant_ch_q <= grant_ch_d;
            rr_q       <= rr_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_grant_ch = grant_ch_q;
    assign o_held     = held_q;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            o_ch_busy[c]  = (ch_q[c].busy == CH_BUSY);
            o_ch_owner[c] = ch_q[c].owner[UNIT_W-1:0];
            o_ch_dest[c]  = ch_q[c].dest[UNIT_W-1:0];
        end
    end

    logic inv_ok;

    always_comb begin
        inv_ok = ($countones(o_ch_busy) == $countones(held_q));
        for (int c1 = 0; c1 < NUM_CHANNELS; c1++) begin
            if ((ch_q[c1].owner >> UNIT_W) != '0 || (ch_q[c1].dest >> UNIT_W) != '0) inv_ok = 1'b0;
            for (int c2 = c1 + 1; c2 < NUM_CHANNELS; c2++) begin
                if (ch_q[c1].busy == CH_BUSY && ch_q[c2].busy == CH_BUSY &&
                    (ch_q[c1].owner == ch_q[c2].owner || ch_q[c1].dest == ch_q[c2].dest))
                    inv_ok = 1'b0;
            end
        end
    end

    a_alloc_consistent: assert property (@(posedge i_clk) disable iff (i_reset) inv_ok);

endmodule

// File: doc/icon_channel_arbiter.md
Name: icon_channel_arbiter

Overview:
- Allocates the NUM_CHANNELS shared interconnect channels of eu_interconnect to the NUM_UNITS execution units.
- Each unit requests a channel towards a destination unit and receives a registered grant carrying a channel index.
- The unit owns that channel until it releases it.
- Allocation is round-robin across units, with at most one active channel per destination unit.
- The grant and owner outputs drive the interconnect's per-channel arbitration select lines.

Parameters:
- NUM_CHANNELS, 2, number of shared channels; must be >= 2.
- NUM_UNITS, 2, number of requesting/receiving units; must be >= 2.
- UNIT_W, max(1,$clog2(NUM_UNITS)), localparam, unit id width.
- CH_W, max(1,$clog2(NUM_CHANNELS)), localparam, channel id width.

Ports:
- i_clk, input, 1, clock; all state updates on rising edge.
- i_reset, input, 1, asynchronous active-high reset.
- i_req, input, NUM_UNITS, unit u requests a channel; held until granted or withdrawn.
- i_req_dest, input, NUM_UNITS x UNIT_W, destination unit id per requester.
- i_release, input, NUM_UNITS, unit u frees its held channel; 1-cycle pulse.
- o_grant, output, NUM_UNITS, 1-cycle pulse: unit u has been granted a channel.
- o_grant_ch, output, NUM_UNITS x CH_W, channel index for unit u; valid with o_grant[u] and for as long as u holds the channel.
- o_held, output, NUM_UNITS, unit u currently owns a channel.
- o_ch_busy, output, NUM_CHANNELS, channel c is allocated.
- o_ch_owner, output, NUM_CHANNELS x UNIT_W, source unit of channel c; 0 when idle.
- o_ch_dest, output, NUM_CHANNELS x UNIT_W, destination unit of channel c; 0 when idle.

Behaviour:
- Reset, asynchronous: all o_* outputs = 0, all channels IDLE, rr_ptr = 0.
  - A reset during a transfer drops all ownership immediately.
  - The first grant is possible on the first edge after reset deasserts.
- Per-channel FSM, IDLE <-> BUSY:
  - IDLE -> BUSY on allocation.
  - BUSY -> IDLE on the edge where i_release[owner] = 1.
- Eligible requester u, evaluated on the registered state at each edge: i_req[u]=1, o_held[u]=0, and i_req_dest[u] is not o_ch_dest of any BUSY channel.
- Allocation, single cycle:
  - Walk eligible units in round-robin order starting at rr_ptr.
  - Assign free channels in ascending index order.
  - Skip any unit whose destination was already assigned earlier in the same walk.
  - Stop when free channels or eligible units are exhausted.
  - Grants appear the edge after the request is sampled: 1-cycle latency, o_grant high for exactly one cycle.
- A channel released at edge N is counted as free from edge N+1; it is never reallocated on the releasing edge.
- i_release[u] with o_held[u]=0 is ignored.
- i_req[u] while o_held[u]=1 is ignored, with no queueing.
- Simultaneous i_release[u] and i_req[u]: release takes effect; the new request competes from the next edge.
- Dropping i_req before grant withdraws the request with no side effects.
- rr_ptr update:
  - When at least one grant issues, rr_ptr = (last granted unit + 1) mod NUM_UNITS, wrapping at NUM_UNITS-1 -> 0.
  - Otherwise rr_ptr is unchanged.
- i_req_dest equal to the requester's own id is legal (loopback) and subject to the same rules.
- Invariants, asserted in RTL:
  - At most one BUSY channel per owner and per destination.
  - popcount(o_ch_busy) = popcount(o_held).

Decomposition:
- Into package exec_unit_dtypes:
  - typedef enum {CH_IDLE, CH_BUSY} type_icon_ch_state.
  - packed struct type_icon_ch_alloc {busy, owner, dest}.
- Sub-module icon_rr_picker, combinational:
  - Inputs: request mask, start pointer, exclusion mask.
  - Outputs: one-hot winner and valid.
- The arbiter chains NUM_CHANNELS instances. Each instance's exclusion mask adds the units already picked and the units targeting destinations already picked.

Test Plan (NUM_UNITS=4, NUM_CHANNELS=2):
1. Reset mid-use: channels 0,1 BUSY, assert i_reset asynchronously -> o_ch_busy=00 and o_held=0000 without waiting for a clock edge; rr_ptr=0.
2. Requests from units 0,1,2 (dests 3,2,1) at edge 0 -> at edge 1, o_grant=0011, o_grant_ch[0]=0, o_grant_ch[1]=1, rr_ptr=2; unit 2 is still pending.
3. From test 2, unit 0 pulses i_release at edge 5 -> ch0 is IDLE after edge 5; unit 2 is granted ch0 at edge 6, not edge 5; rr_ptr=3.
4. Units 1 and 3 both request dest 0, rr_ptr=0, channels free -> only unit 1 is granted; unit 3 is granted the edge after unit 1 releases.
5. Fairness: all 4 units continuously re-request after each release, with one-cycle holds -> the grant order rotates 0,1,2,3,0,...; no unit waits more than 2 allocation rounds.
6. Stray pulses: i_release[2] with unit 2 not holding, and i_req[0] while unit 0 holds ch1 -> no state change, no o_grant pulse.
